// File: rtl/disp_scan.sv
// ---------------------------------------------------------------------------
// disp_scan -- time-multiplexed 7-segment display scanner
//
// Drives DIGITS common-enabled digits from one shared BCD/hex decoder.
// Each digit slot is DEAD dark (anti-ghosting) cycles followed by SCAN_DIV
// lit cycles.  New display data is captured into a pending buffer by `load`
// and only promoted to the displayed (active) buffer at a frame boundary,
// or straight away while the scanner is idle, so a frame never tears.
//
// Optional feature macro: DISP_SCAN_LZ_BLANK_EN
//   defined   : leading-zero blanking.  Digits above the most significant
//               nonzero nibble stay dark in their slot (timing unchanged);
//               digit 0 and any digit with its decimal point set stay lit.
//   undefined : every digit is lit in its slot.
//
// Parameters
//   DIGITS    number of multiplexed digits (1..8)
//   SCAN_DIV  lit cycles per digit slot (>=1)
//   DEAD      dark cycles before each digit slot (>=0)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      scanning runs while high, display dark while low
//   value       4*DIGITS nibbles, nibble i drives digit i
//   dp          decimal point per digit
//   load        one-cycle strobe capturing value/dp into the pending buffer
//   bcd         nibble for the shared 7-segment decoder
//   dp_o        decimal point of the current digit
//   digit_en    one-hot active-high digit common enable
//   frame_done  one-cycle pulse on the first cycle of each new frame
// ---------------------------------------------------------------------------
module disp_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEAD     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    output logic [3:0]            bcd,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int MAXC = (SCAN_DIV > DEAD) ? SCAN_DIV : DEAD;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = (DEAD > 0) ? CW'(DEAD - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_idx;
    logic [CW-1:0]          r_cnt;
    logic [4*DIGITS-1:0]    r_act_val;
    logic [DIGITS-1:0]      r_act_dp;
    logic [4*DIGITS-1:0]    r_pend_val;
    logic [DIGITS-1:0]      r_pend_dp;
    logic                   r_pend_vld;
    logic [3:0]             r_bcd;
    logic                   r_dp_o;
    logic [DIGITS-1:0]      r_digit_en;
    logic                   r_frame_done;

    state_t                 w_state_next;
    logic [IW-1:0]          w_idx_next;
    logic [CW-1:0]          w_cnt_next;
    logic                   w_boundary;
    logic [4*DIGITS-1:0]    w_act_val_next;
    logic [DIGITS-1:0]      w_act_dp_next;
    logic [4*DIGITS-1:0]    w_pend_val_next;
    logic [DIGITS-1:0]      w_pend_dp_next;
    logic                   w_pend_vld_next;
    logic                   w_lit;
    logic [3:0]             w_bcd_next;
    logic                   w_dp_next;
    logic [DIGITS-1:0]      w_en_next;

    // Sequencing: slot timing, digit index and frame boundary detection.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_boundary   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idx_next = '0;
                w_cnt_next = '0;
                if (enable) begin
                    w_state_next = (DEAD > 0) ? ST_BLANK : ST_SHOW;
                end
            end
            ST_BLANK: begin
                if (r_cnt == DEAD_LAST) begin
                    w_state_next = ST_SHOW;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_SHOW: begin
                if (r_cnt == SCAN_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = (DEAD > 0) ? ST_BLANK : ST_SHOW;
                    w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    w_boundary   = (r_idx == IDX_LAST);
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        // Dropping enable wins over everything, including a pending boundary.
        if (!enable) begin
            w_state_next = ST_IDLE;
            w_idx_next   = '0;
            w_cnt_next   = '0;
            w_boundary   = 1'b0;
        end
    end

    // Double buffering.  A load in the boundary cycle is promoted in the same
    // edge because the transfer looks at the post-load pending contents.
    always_comb begin
        w_pend_val_next = r_pend_val;
        w_pend_dp_next  = r_pend_dp;
        w_pend_vld_next = r_pend_vld;
        w_act_val_next  = r_act_val;
        w_act_dp_next   = r_act_dp;
        if (load) begin
            w_pend_val_next = value;
            w_pend_dp_next  = dp;
            w_pend_vld_next = 1'b1;
        end
        if ((w_boundary || (r_state == ST_IDLE)) && w_pend_vld_next) begin
            w_act_val_next  = w_pend_val_next;
            w_act_dp_next   = w_pend_dp_next;
            w_pend_vld_next = 1'b0;
        end
    end

`ifdef DISP_SCAN_LZ_BLANK_EN
    logic [DIGITS-1:0] w_nz;
    logic [DIGITS-1:0] w_nz_up;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nz
            assign w_nz[gi] = |w_act_val_next[4*gi +: 4];
        end
    endgenerate

    // A digit is a leading zero when no nibble at or above it is nonzero.
    assign w_nz_up = w_nz >> w_idx_next;
    assign w_lit   = (w_idx_next == '0) || w_act_dp_next[w_idx_next] || (|w_nz_up);
`else
    assign w_lit = 1'b1;
`endif

    // Outputs are computed for the state being entered so they register
    // in step with it.
    always_comb begin
        w_bcd_next = w_act_val_next[{w_idx_next, 2'b00} +: 4];
        w_dp_next  = w_act_dp_next[w_idx_next];
        w_en_next  = '0;
        if ((w_state_next == ST_SHOW) && w_lit) begin
            w_en_next = DIGITS'(1) << w_idx_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_act_val    <= '0;
            r_act_dp     <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_vld   <= 1'b0;
            r_bcd        <= '0;
            r_dp_o       <= 1'b0;
            r_digit_en   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_cnt        <= w_cnt_next;
            r_act_val    <= w_act_val_next;
            r_act_dp     <= w_act_dp_next;
            r_pend_val   <= w_pend_val_next;
            r_pend_dp    <= w_pend_dp_next;
            r_pend_vld   <= w_pend_vld_next;
            r_bcd        <= w_bcd_next;
            r_dp_o       <= w_dp_next;
            r_digit_en   <= w_en_next;
            r_frame_done <= w_boundary;
        end
    end

    assign bcd        = r_bcd;
    assign dp_o       = r_dp_o;
    assign digit_en   = r_digit_en;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_disp_scan.sv
// ---------------------------------------------------------------------------
// tb_disp_scan -- self-checking bench for disp_scan (DIGITS=4, SCAN_DIV=4,
// DEAD=1, frame = 20 cycles).  A positional reference model (cycle number
// within the frame -> slot and phase) predicts every output each cycle;
// directed vectors and hand-written sequences cover frame timing, buffered
// loads, enable drop and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_disp_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  bcd;
    logic        dp_o;
    logic [3:0]  digit_en;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

`ifdef DISP_SCAN_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    always #5 clk = ~clk;

    disp_scan #(
        .DIGITS   (4),
        .SCAN_DIV (4),
        .DEAD     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .bcd        (bcd),
        .dp_o       (dp_o),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    // ---------------- reference model ----------------
    bit          m_run;
    int          m_t;       // cycles since scanning started
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_adp, m_pdp;
    bit          m_pvld;
    logic [3:0]  e_en, e_bcd;
    logic        e_dp, e_fd;

    function automatic bit m_lit(int s, logic [15:0] a, logic [3:0] d);
        int msd = 0;
        for (int j = 0; j < 4; j++) begin
            if (a[4*j +: 4] != 4'h0) msd = j;
        end
        return !LZ || (s <= msd) || d[s];
    endfunction

    task automatic m_reset();
        m_run = 0; m_t = 0; m_act = '0; m_pend = '0;
        m_adp = '0; m_pdp = '0; m_pvld = 0;
        e_en = '0; e_bcd = '0; e_dp = 1'b0; e_fd = 1'b0;
    endtask

    task automatic m_edge(input logic en, input logic ld, input logic [15:0] v, input logic [3:0] d);
        bit bnd;
        int p;
        int s;
        bnd = m_run && en && ((m_t % 20) == 19);
        if (ld) begin
            m_pend = v; m_pdp = d; m_pvld = 1;
        end
        if ((!m_run || bnd) && m_pvld) begin
            m_act = m_pend; m_adp = m_pdp; m_pvld = 0;
        end
        if (!en) begin
            m_run = 0; m_t = 0;
        end else if (!m_run) begin
            m_run = 1; m_t = 0;
        end else begin
            m_t++;
        end
        if (m_run) begin
            p     = m_t % 20;
            s     = p / 5;
            e_en  = (((p % 5) != 0) && m_lit(s, m_act, m_adp)) ? 4'(1 << s) : 4'b0000;
            e_bcd = m_act[4*s +: 4];
            e_dp  = m_adp[s];
            e_fd  = (m_t > 0) && (p == 0);
        end else begin
            e_en  = '0;
            e_fd  = 1'b0;
            e_bcd = m_act[3:0];
            e_dp  = m_adp[0];
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", nm, m_t, got, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare.
    task automatic tick(input logic en, input logic ld, input logic [15:0] v, input logic [3:0] d);
        enable = en; load = ld; value = v; dp = d;
        @(posedge clk);
        m_edge(en, ld, v, d);
        @(negedge clk);
        load = 1'b0;
        chk("digit_en", {12'h0, digit_en}, {12'h0, e_en});
        chk("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
        if (m_run) begin
            chk("bcd", {12'h0, bcd}, {12'h0, e_bcd});
            chk("dp_o", {15'h0, dp_o}, {15'h0, e_dp});
        end
    endtask

    task automatic run_to(input int t);
        int guard = 0;
        while (m_run && (m_t < t) && (guard < 200)) begin
            tick(1'b1, 1'b0, value, dp);
            guard++;
        end
    endtask

    typedef struct {
        int         t;
        logic [3:0] en;
        logic [3:0] bcd;
        logic       fd;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #500000;
        $display("FAIL timeout t=%0d", m_t);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        // value 1234 scanned: slot = 1 dark + 4 lit cycles, frame 20 cycles
        tbl[0]  = '{0,  4'b0000, 4'h4, 1'b0};
        tbl[1]  = '{1,  4'b0001, 4'h4, 1'b0};
        tbl[2]  = '{4,  4'b0001, 4'h4, 1'b0};
        tbl[3]  = '{5,  4'b0000, 4'h3, 1'b0};
        tbl[4]  = '{6,  4'b0010, 4'h3, 1'b0};
        tbl[5]  = '{10, 4'b0000, 4'h2, 1'b0};
        tbl[6]  = '{11, 4'b0100, 4'h2, 1'b0};
        tbl[7]  = '{15, 4'b0000, 4'h1, 1'b0};
        tbl[8]  = '{16, 4'b1000, 4'h1, 1'b0};
        tbl[9]  = '{19, 4'b1000, 4'h1, 1'b0};
        tbl[10] = '{20, 4'b0000, 4'h4, 1'b1};
        tbl[11] = '{21, 4'b0001, 4'h4, 1'b0};
        tbl[12] = '{40, 4'b0000, 4'h4, 1'b1};

        rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = '0; dp = '0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_digit_en", {12'h0, digit_en}, 16'h0);
        chk("rst_bcd", {12'h0, bcd}, 16'h0);
        chk("rst_dp_o", {15'h0, dp_o}, 16'h0);
        chk("rst_frame_done", {15'h0, frame_done}, 16'h0);
        $display("reset state checked");
        rst_n = 1'b1;

        // load while idle, then start scanning
        tick(1'b0, 1'b1, 16'h1234, 4'b0000);
        tick(1'b0, 1'b0, 16'h1234, 4'b0000);
        tick(1'b1, 1'b0, 16'h1234, 4'b0000);

        for (int i = 0; i < 13; i++) begin
            run_to(tbl[i].t);
            chk($sformatf("vec%0d_en", i), {12'h0, digit_en}, {12'h0, tbl[i].en});
            chk($sformatf("vec%0d_bcd", i), {12'h0, bcd}, {12'h0, tbl[i].bcd});
            chk($sformatf("vec%0d_fd", i), {15'h0, frame_done}, {15'h0, tbl[i].fd});
            $display("vec %0d t=%0d en=%b bcd=%h fd=%b", i, m_t, digit_en, bcd, frame_done);
        end

        // mid-frame load: current frame completes with old value
        run_to(47);
        tick(1'b1, 1'b1, 16'h5678, 4'b0000);
        run_to(59);
        chk("mid_old_bcd", {12'h0, bcd}, 16'h1);
        chk("mid_old_en", {12'h0, digit_en}, 16'h8);
        tick(1'b1, 1'b0, 16'h5678, 4'b0000);
        chk("mid_new_bcd", {12'h0, bcd}, 16'h8);
        chk("mid_new_fd", {15'h0, frame_done}, 16'h1);
        tick(1'b1, 1'b0, 16'h5678, 4'b0000);
        chk("mid_new_en", {12'h0, digit_en}, 16'h1);
        $display("mid-frame load t=%0d bcd=%h en=%b", m_t, bcd, digit_en);

        // load in the last lit cycle of the frame goes straight to display
        run_to(79);
        tick(1'b1, 1'b1, 16'h9ABC, 4'b0001);
        chk("bnd_bcd", {12'h0, bcd}, 16'hC);
        chk("bnd_dp", {15'h0, dp_o}, 16'h1);
        chk("bnd_fd", {15'h0, frame_done}, 16'h1);
        $display("boundary load t=%0d bcd=%h dp=%b", m_t, bcd, dp_o);

        // load during the frame_done cycle shows from the following frame
        tick(1'b1, 1'b1, 16'hABCD, 4'b0000);
        chk("fd_load_old", {12'h0, bcd}, 16'hC);
        run_to(100);
        chk("fd_load_new", {12'h0, bcd}, 16'hD);
        chk("fd_load_fd", {15'h0, frame_done}, 16'h1);
        run_to(106);
        chk("fd_load_d1", {12'h0, bcd}, 16'hC);
        chk("fd_load_en", {12'h0, digit_en}, 16'h2);
        $display("frame_done load t=%0d bcd=%h en=%b", m_t, bcd, digit_en);

        // enable dropped while digit 2 is lit
        run_to(112);
        chk("en_drop_pre", {12'h0, digit_en}, 16'h4);
        tick(1'b0, 1'b0, 16'hABCD, 4'b0000);
        chk("en_drop_en", {12'h0, digit_en}, 16'h0);
        chk("en_drop_fd", {15'h0, frame_done}, 16'h0);
        tick(1'b0, 1'b0, 16'hABCD, 4'b0000);
        tick(1'b0, 1'b0, 16'hABCD, 4'b0000);
        tick(1'b1, 1'b0, 16'hABCD, 4'b0000);
        chk("reen_blank", {12'h0, digit_en}, 16'h0);
        chk("reen_bcd", {12'h0, bcd}, 16'hD);
        tick(1'b1, 1'b0, 16'hABCD, 4'b0000);
        chk("reen_d0", {12'h0, digit_en}, 16'h1);
        $display("enable drop/restart t=%0d en=%b bcd=%h", m_t, digit_en, bcd);

        // asynchronous reset just before a frame boundary
        run_to(19);
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        chk("arst_en", {12'h0, digit_en}, 16'h0);
        chk("arst_bcd", {12'h0, bcd}, 16'h0);
        chk("arst_dp", {15'h0, dp_o}, 16'h0);
        chk("arst_fd", {15'h0, frame_done}, 16'h0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("arst_hold_fd", {15'h0, frame_done}, 16'h0);
            chk("arst_hold_en", {12'h0, digit_en}, 16'h0);
        end
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 16'h0000, 4'b0000);
        chk("rst_restart_en", {12'h0, digit_en}, 16'h0);
        tick(1'b1, 1'b0, 16'h0000, 4'b0000);
        chk("rst_restart_d0", {12'h0, digit_en}, 16'h1);
        $display("async reset/restart t=%0d en=%b", m_t, digit_en);

        // leading-zero behaviour (all digits lit when the feature is off)
        tick(1'b1, 1'b1, 16'h0070, 4'b0000);
        run_to(20);
        chk("lz_fd", {15'h0, frame_done}, 16'h1);
        run_to(21);
        chk("lz70_d0", {12'h0, digit_en}, 16'h1);
        run_to(26);
        chk("lz70_d1", {12'h0, digit_en}, 16'h2);
        run_to(31);
        chk("lz70_d2", {12'h0, digit_en}, LZ ? 16'h0 : 16'h4);
        run_to(36);
        chk("lz70_d3", {12'h0, digit_en}, LZ ? 16'h0 : 16'h8);
        tick(1'b1, 1'b1, 16'h0000, 4'b0000);
        run_to(40);
        chk("lz_fd2", {15'h0, frame_done}, 16'h1);
        run_to(41);
        chk("lz00_d0", {12'h0, digit_en}, 16'h1);
        run_to(46);
        chk("lz00_d1", {12'h0, digit_en}, LZ ? 16'h0 : 16'h2);
        tick(1'b1, 1'b1, 16'h0000, 4'b0100);
        run_to(60);
        chk("lz_fd3", {15'h0, frame_done}, 16'h1);
        run_to(71);
        chk("lzdp_d2", {12'h0, digit_en}, 16'h4);
        chk("lzdp_dp", {15'h0, dp_o}, 16'h1);
        $display("leading-zero checks t=%0d lz=%0d", m_t, LZ);

        // randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            tick(($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                 16'($urandom), 4'($urandom));
        end
        $display("random phase done t=%0d", m_t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
